// File: rtl/led_ctrl_pkg.sv
// Shared encodings and default clocking constants for the LED sequencer.
package led_ctrl_pkg;

    // Command mode encodings as carried on cmd_mode.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    // Sequencer states: IDLE and OFF_PH drive 0, HOLD and ON_PH drive the mask.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_ON_PH  = 2'd2,
        ST_OFF_PH = 2'd3
    } state_e;

    // Board defaults: 50 MHz clock, 1 ms tick.
    localparam int DEF_CLK_HZ  = 50_000_000;
    localparam int DEF_TICK_HZ = 1000;
    localparam int DEF_DIV     = DEF_CLK_HZ / DEF_TICK_HZ;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
// clr restarts the count so the next tick lands exactly DIV clocks later.
// CLK_HZ/TICK_HZ must be at least 2.
module tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    // Next count: restart on clear, wrap after the terminal count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Command-driven LED sequencer: OFF / ON / BLINK / BURST with tick-based
// on/off phase timing. Commands are latched on accept; LEDs update one
// cycle later from a registered output.
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int TICK_HZ  = DEF_TICK_HZ,
    parameter int NUM_LEDS = 4,
    parameter int TIME_W   = 16,
    parameter int REP_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [NUM_LEDS-1:0] cmd_mask,
    input  logic [TIME_W-1:0]   cmd_on_t,
    input  logic [TIME_W-1:0]   cmd_off_t,
    input  logic [REP_W-1:0]    cmd_rep,
    output logic [NUM_LEDS-1:0] leds,
    output logic                busy,
    output logic                done
);

    // A zero length or count behaves as one.
    function automatic logic [TIME_W-1:0] min1_time(input logic [TIME_W-1:0] v);
        return (v == '0) ? TIME_W'(1) : v;
    endfunction

    function automatic logic [REP_W-1:0] min1_rep(input logic [REP_W-1:0] v);
        return (v == '0) ? REP_W'(1) : v;
    endfunction

    state_e                state_q, state_d;
    mode_e                 mode_q,  mode_d;
    logic [NUM_LEDS-1:0]   mask_q,  mask_d;
    logic [TIME_W-1:0]     on_q,    on_d;
    logic [TIME_W-1:0]     off_q,   off_d;
    logic [REP_W-1:0]      rep_q,   rep_d;
    logic [TIME_W-1:0]     timer_q, timer_d;
    logic [NUM_LEDS-1:0]   leds_q,  leds_d;
    logic                  done_q,  done_d;
    logic                  accept;
    logic                  tick;
    logic                  phase_end;

    assign accept    = cmd_valid && cmd_ready;
    assign phase_end = tick && (timer_q == TIME_W'(1));

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    // Ready in IDLE/HOLD and while blinking; a burst holds it low until the cycle after done.
    always_comb begin
        cmd_ready = 1'b1;
        if (state_q == ST_ON_PH || state_q == ST_OFF_PH) begin
            cmd_ready = (mode_q == MODE_BLINK);
        end
        if (done_q) begin
            cmd_ready = 1'b0;
        end
    end

    assign busy = (state_q == ST_ON_PH) || (state_q == ST_OFF_PH);
    assign leds = leds_q;
    assign done = done_q;

    // Next-state: an accepted command always wins over a phase end in the same cycle.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        on_d    = on_q;
        off_d   = off_q;
        rep_d   = rep_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        leds_d  = '0;

        if (accept) begin
            mode_d  = mode_e'(cmd_mode);
            mask_d  = cmd_mask;
            on_d    = min1_time(cmd_on_t);
            off_d   = min1_time(cmd_off_t);
            rep_d   = min1_rep(cmd_rep);
            timer_d = min1_time(cmd_on_t);
            case (mode_e'(cmd_mode))
                MODE_OFF: state_d = ST_IDLE;
                MODE_ON:  state_d = ST_HOLD;
                default:  state_d = ST_ON_PH;
            endcase
        end else if (tick) begin
            case (state_q)
                ST_ON_PH: begin
                    if (phase_end) begin
                        state_d = ST_OFF_PH;
                        timer_d = off_q;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_OFF_PH: begin
                    if (!phase_end) begin
                        timer_d = timer_q - 1'b1;
                    end else if (mode_q == MODE_BURST && rep_q == REP_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ON_PH;
                        timer_d = on_q;
                        if (mode_q == MODE_BURST) begin
                            rep_d = rep_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (state_d == ST_HOLD || state_d == ST_ON_PH) begin
            leds_d = mask_d;
        end
    end

    // State, command, timer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            mask_q  <= '0;
            on_q    <= '0;
            off_q   <= '0;
            rep_q   <= '0;
            timer_q <= '0;
            leds_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            on_q    <= on_d;
            off_q   <= off_d;
            rep_q   <= rep_d;
            timer_q <= timer_d;
            leds_q  <= leds_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: table-driven vectors, hand-written corner sequences
// and randomized commands against a phase-arithmetic reference model.
module tb_led_seq_ctrl;

    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 250;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int NUM_LEDS = 4;
    localparam int TIME_W   = 12;
    localparam int REP_W    = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_mode;
    logic [NUM_LEDS-1:0] cmd_mask;
    logic [TIME_W-1:0]   cmd_on_t;
    logic [TIME_W-1:0]   cmd_off_t;
    logic [REP_W-1:0]    cmd_rep;
    logic [NUM_LEDS-1:0] leds;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .NUM_LEDS (NUM_LEDS),
        .TIME_W   (TIME_W),
        .REP_W    (REP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_mask  (cmd_mask),
        .cmd_on_t  (cmd_on_t),
        .cmd_off_t (cmd_off_t),
        .cmd_rep   (cmd_rep),
        .leds      (leds),
        .busy      (busy),
        .done      (done)
    );

    // Reference model: last accepted command and cycles elapsed since it.
    int m_active = 0;
    int m_mode, m_mask, m_on, m_off, m_rep;
    int m_t;

    function automatic void model_out(output int el, output int eb, output int ed, output int er);
        int a, p, tot;
        el = 0; eb = 0; ed = 0; er = 1;
        if (m_active != 0) begin
            a   = m_on * DIV;
            p   = a + m_off * DIV;
            tot = m_rep * p;
            case (m_mode)
                1: el = m_mask;
                2: begin
                    el = ((m_t % p) < a) ? m_mask : 0;
                    eb = 1;
                end
                3: begin
                    if (m_t < tot) begin
                        el = ((m_t % p) < a) ? m_mask : 0;
                        eb = 1;
                        er = 0;
                    end else if (m_t == tot) begin
                        ed = 1;
                        er = 0;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: advance model alongside DUT, then compare all outputs.
    task automatic cycle();
        int el, eb, ed, er;
        bit acc;
        int c_mode, c_mask, c_on, c_off, c_rep;
        model_out(el, eb, ed, er);
        acc    = rst_n && cmd_valid && (er != 0);
        c_mode = int'(cmd_mode);
        c_mask = int'(cmd_mask);
        c_on   = (cmd_on_t == '0)  ? 1 : int'(cmd_on_t);
        c_off  = (cmd_off_t == '0) ? 1 : int'(cmd_off_t);
        c_rep  = (cmd_rep == '0)   ? 1 : int'(cmd_rep);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_active = 0;
        end else if (acc) begin
            m_active = 1;
            m_mode = c_mode; m_mask = c_mask;
            m_on = c_on; m_off = c_off; m_rep = c_rep;
            m_t = 0;
        end else begin
            m_t++;
        end
        model_out(el, eb, ed, er);
        check("model_leds",  int'(leds),      el);
        check("model_busy",  int'(busy),      eb);
        check("model_done",  int'(done),      ed);
        check("model_ready", int'(cmd_ready), er);
    endtask

    task automatic drive(input logic v, input logic [1:0] mo, input logic [3:0] mk,
                         input logic [TIME_W-1:0] on, input logic [TIME_W-1:0] off,
                         input logic [REP_W-1:0] rep);
        cmd_valid = v; cmd_mode = mo; cmd_mask = mk;
        cmd_on_t = on; cmd_off_t = off; cmd_rep = rep;
    endtask

    typedef struct {
        logic              valid;
        logic [1:0]        mode;
        logic [3:0]        mask;
        logic [TIME_W-1:0] on_t;
        logic [TIME_W-1:0] off_t;
        logic [REP_W-1:0]  rep;
        int                n;
        logic [3:0]        el;
        logic              eb;
        logic              ed;
        logic              er;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // valid mode mask on off rep | clocks | leds busy done ready
        tbl[0]  = '{1'b1, 2'd1, 4'b0101, 12'd0, 12'd0, 8'd0,  1, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0, 20, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 12'd0, 12'd0, 8'd0,  1, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'd2, 4'b1111, 12'd2, 12'd3, 8'd0,  1, 4'hF, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0,  7, 4'hF, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0,  1, 4'h0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0, 11, 4'h0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0,  1, 4'hF, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0, 80, 4'hF, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0,  8, 4'h0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 2'd3, 4'b0001, 12'd1, 12'd1, 8'd3,  1, 4'h1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 4'b1111, 12'd0, 12'd0, 8'd0,  3, 4'h1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0,  1, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0, 20, 4'h0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 4'b0000, 12'd0, 12'd0, 8'd0,  1, 4'h0, 1'b0, 1'b0, 1'b1};

        // Reset state, held for 10 clocks.
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 4'h0, '0, '0, '0);
        #2;
        check("rst_leds", int'(leds), 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("rst_leds_hold",  int'(leds),      0);
            check("rst_busy_hold",  int'(busy),      0);
            check("rst_done_hold",  int'(done),      0);
            check("rst_ready_hold", int'(cmd_ready), 1);
        end
        rst_n = 1'b1;
        cycle();

        // Table: ON / OFF / BLINK periods / BURST with an ignored command.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].valid, tbl[i].mode, tbl[i].mask, tbl[i].on_t, tbl[i].off_t, tbl[i].rep);
            cycle();
            cmd_valid = 1'b0;
            for (int k = 1; k < tbl[i].n; k++) cycle();
            check($sformatf("vec%0d_leds", i),  int'(leds),      int'(tbl[i].el));
            check($sformatf("vec%0d_busy", i),  int'(busy),      int'(tbl[i].eb));
            check($sformatf("vec%0d_done", i),  int'(done),      int'(tbl[i].ed));
            check($sformatf("vec%0d_ready", i), int'(cmd_ready), int'(tbl[i].er));
        end

        // New ON command exactly on the BLINK on-phase end tick.
        drive(1'b1, 2'd2, 4'b1010, 12'd1, 12'd1, 8'd0);
        cycle();
        cmd_valid = 1'b0;
        repeat (3) cycle();
        check("pre_leds", int'(leds), 4'hA);
        drive(1'b1, 2'd1, 4'b0110, 12'd0, 12'd0, 8'd0);
        cycle();
        cmd_valid = 1'b0;
        check("preempt_leds", int'(leds), 4'h6);
        check("preempt_busy", int'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("preempt_no_done", int'(done), 0);
            check("preempt_hold",    int'(leds), 4'h6);
        end

        // BURST with zero fields acts as one 4-clock pulse.
        drive(1'b1, 2'd3, 4'b1000, 12'd0, 12'd0, 8'd0);
        cycle();
        cmd_valid = 1'b0;
        repeat (3) cycle();
        check("b0_last_on", int'(leds), 4'h8);
        cycle();
        check("b0_off", int'(leds), 0);
        repeat (4) cycle();
        check("b0_done", int'(done), 1);
        check("b0_ready_at_done", int'(cmd_ready), 0);
        cycle();
        check("b0_ready_after", int'(cmd_ready), 1);

        // Asynchronous reset mid-pulse.
        drive(1'b1, 2'd3, 4'b0100, 12'd0, 12'd0, 8'd0);
        cycle();
        cmd_valid = 1'b0;
        repeat (2) cycle();
        check("mid_leds", int'(leds), 4'h4);
        #2;
        rst_n = 1'b0;
        #1;
        m_active = 0;
        check("async_leds", int'(leds), 0);
        check("async_busy", int'(busy), 0);
        repeat (3) begin
            cycle();
            check("async_no_done", int'(done), 0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            cycle();
            check("post_rst_no_done", int'(done), 0);
        end

        // Maximum on time is honoured without wrap.
        drive(1'b1, 2'd3, 4'b1111, 12'hFFF, 12'd1, 8'd1);
        cycle();
        cmd_valid = 1'b0;
        repeat (4095 * DIV - 1) cycle();
        check("max_last_on", int'(leds), 4'hF);
        cycle();
        check("max_off", int'(leds), 0);
        check("max_busy", int'(busy), 1);
        repeat (DIV) cycle();
        check("max_done", int'(done), 1);

        // Randomized command traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                drive(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      TIME_W'($urandom_range(0, 3)), TIME_W'($urandom_range(0, 3)),
                      REP_W'($urandom_range(0, 3)));
            end else begin
                cmd_valid = 1'b0;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
